// File: rtl/stage_sequencer.sv
// Stage sequencer for the multi-cycle processor: steps each instruction through
// stages 1..NUM_STAGES under run/step/stall control, with decoder-requested halt.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Step,
    input  logic             Stall,
    input  logic             Halt_Req,
    output logic [2:0]       Stage,
    output logic             Busy,
    output logic             Halted,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [2:0] LAST = 3'(NUM_STAGES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    logic   single;
    logic   halt_pending;
    logic   halt_now;

    // With NUM_STAGES=2 the halt request arrives on the retiring edge itself.
    always_comb begin
        halt_now = halt_pending || (Stage == 3'd2 && Halt_Req);
    end

    // NOTE: every register here uses non-blocking assignments so that all
    // next-state decisions read the pre-edge values of Stage/Busy/state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            Stage        <= 3'd0;
            Busy         <= 1'b0;
            Halted       <= 1'b0;
            InstrDone    <= 1'b0;
            InstrCount   <= '0;
            CycleCount   <= '0;
            single       <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            InstrDone <= 1'b0;

            if (Busy && CycleCount != '1) begin
                CycleCount <= CycleCount + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (Run || Step) begin
                        state        <= ACTIVE;
                        Stage        <= 3'd1;
                        Busy         <= 1'b1;
                        single       <= !Run;
                        halt_pending <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (Stage == 3'd0 || Stage > LAST) begin
                        state        <= IDLE;
                        Stage        <= 3'd0;
                        Busy         <= 1'b0;
                        halt_pending <= 1'b0;
                    end else if (!Stall) begin
                        if (Stage == 3'd2 && Halt_Req) begin
                            halt_pending <= 1'b1;
                        end
                        if (Stage < LAST) begin
                            Stage <= Stage + 3'd1;
                        end else begin
                            InstrDone  <= 1'b1;
                            InstrCount <= InstrCount + CNT_W'(1);
                            if (halt_now) begin
                                state        <= HALTED;
                                Stage        <= 3'd0;
                                Busy         <= 1'b0;
                                Halted       <= 1'b1;
                                halt_pending <= 1'b0;
                            end else if (!single && Run) begin
                                Stage <= 3'd1;
                            end else begin
                                state        <= IDLE;
                                Stage        <= 3'd0;
                                Busy         <= 1'b0;
                                halt_pending <= 1'b0;
                            end
                        end
                    end
                end

                HALTED: begin
                    Stage  <= 3'd0;
                    Busy   <= 1'b0;
                    Halted <= 1'b1;
                end

                default: begin
                    state        <= IDLE;
                    Stage        <= 3'd0;
                    Busy         <= 1'b0;
                    Halted       <= 1'b0;
                    halt_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a table of per-edge vectors plus
// hand-written sequences for async reset and counter wrap/saturation.
module tb_stage_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Run, Step, Stall, Halt_Req;
    logic [2:0]  Stage;
    logic        Busy, Halted, InstrDone;
    logic [15:0] InstrCount, CycleCount;

    logic        run2;
    logic [2:0]  stage2;
    logic        busy2, halted2, done2;
    logic [3:0]  icnt2, ccnt2;

    int n_checks = 0;
    int n_errors = 0;

    stage_sequencer #(.NUM_STAGES(5), .CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step), .Stall(Stall),
        .Halt_Req(Halt_Req), .Stage(Stage), .Busy(Busy), .Halted(Halted),
        .InstrDone(InstrDone), .InstrCount(InstrCount), .CycleCount(CycleCount)
    );

    stage_sequencer #(.NUM_STAGES(5), .CNT_W(4)) dut_small (
        .Clock(Clock), .Reset(Reset), .Run(run2), .Step(1'b0), .Stall(1'b0),
        .Halt_Req(1'b0), .Stage(stage2), .Busy(busy2), .Halted(halted2),
        .InstrDone(done2), .InstrCount(icnt2), .CycleCount(ccnt2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        run;
        logic        step;
        logic        stall;
        logic        hreq;
        logic [2:0]  stage;
        logic        busy;
        logic        halted;
        logic        done;
        logic [15:0] icnt;
        logic [15:0] ccnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic st, input logic h,
                       input logic [2:0] stg, input logic b, input logic hl,
                       input logic d, input logic [15:0] ic, input logic [15:0] cc);
        vec_t v;
        v = '{run: r, step: s, stall: st, hreq: h, stage: stg, busy: b,
              halted: hl, done: d, icnt: ic, ccnt: cc};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " Stage"},      {29'd0, Stage},  {29'd0, v.stage});
        check({tag, " Busy"},       {31'd0, Busy},   {31'd0, v.busy});
        check({tag, " Halted"},     {31'd0, Halted}, {31'd0, v.halted});
        check({tag, " InstrDone"},  {31'd0, InstrDone}, {31'd0, v.done});
        check({tag, " InstrCount"}, {16'd0, InstrCount}, {16'd0, v.icnt});
        check({tag, " CycleCount"}, {16'd0, CycleCount}, {16'd0, v.ccnt});
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        vec_t zero_v;
        // Run: two back-to-back instructions, Run drops before the second retires.
        //   r  s  st h  stg b  hl d  ic  cc
        add(1, 0, 0, 0, 1, 1, 0, 0, 0,  0);
        add(1, 0, 0, 0, 2, 1, 0, 0, 0,  1);
        add(1, 0, 0, 0, 3, 1, 0, 0, 0,  2);
        add(1, 0, 0, 0, 4, 1, 0, 0, 0,  3);
        add(1, 0, 0, 0, 5, 1, 0, 0, 0,  4);
        add(1, 0, 0, 0, 1, 1, 0, 1, 1,  5);
        add(1, 0, 0, 0, 2, 1, 0, 0, 1,  6);
        add(1, 0, 0, 0, 3, 1, 0, 0, 1,  7);
        add(1, 0, 0, 0, 4, 1, 0, 0, 1,  8);
        add(1, 0, 0, 0, 5, 1, 0, 0, 1,  9);
        add(0, 0, 0, 0, 0, 0, 0, 1, 2, 10);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2, 10);
        // Single step; Step held from stage 3 onward must not reissue.
        add(0, 1, 0, 0, 1, 1, 0, 0, 2, 10);
        add(0, 0, 0, 0, 2, 1, 0, 0, 2, 11);
        add(0, 0, 0, 0, 3, 1, 0, 0, 2, 12);
        add(0, 1, 0, 0, 4, 1, 0, 0, 2, 13);
        add(0, 1, 0, 0, 5, 1, 0, 0, 2, 14);
        add(0, 1, 0, 0, 0, 0, 0, 1, 3, 15);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3, 15);
        // Stall three cycles in stage 4: instruction takes 8 busy edges.
        add(1, 0, 0, 0, 1, 1, 0, 0, 3, 15);
        add(1, 0, 0, 0, 2, 1, 0, 0, 3, 16);
        add(1, 0, 0, 0, 3, 1, 0, 0, 3, 17);
        add(1, 0, 0, 0, 4, 1, 0, 0, 3, 18);
        add(1, 0, 1, 0, 4, 1, 0, 0, 3, 19);
        add(1, 0, 1, 0, 4, 1, 0, 0, 3, 20);
        add(1, 0, 1, 0, 4, 1, 0, 0, 3, 21);
        add(1, 0, 0, 0, 5, 1, 0, 0, 3, 22);
        add(0, 0, 0, 0, 0, 0, 0, 1, 4, 23);
        // Halt_Req during stage 3 is ignored; during stage 2 it halts at retire.
        add(1, 0, 0, 0, 1, 1, 0, 0, 4, 23);
        add(1, 0, 0, 0, 2, 1, 0, 0, 4, 24);
        add(1, 0, 0, 0, 3, 1, 0, 0, 4, 25);
        add(1, 0, 0, 1, 4, 1, 0, 0, 4, 26);
        add(1, 0, 0, 0, 5, 1, 0, 0, 4, 27);
        add(1, 0, 0, 0, 1, 1, 0, 1, 5, 28);
        add(1, 0, 0, 0, 2, 1, 0, 0, 5, 29);
        add(1, 0, 0, 1, 3, 1, 0, 0, 5, 30);
        add(1, 0, 0, 0, 4, 1, 0, 0, 5, 31);
        add(1, 0, 0, 0, 5, 1, 0, 0, 5, 32);
        add(1, 0, 0, 0, 0, 0, 1, 1, 6, 33);
        add(1, 1, 0, 0, 0, 0, 1, 0, 6, 33);
        add(0, 1, 1, 1, 0, 0, 1, 0, 6, 33);

        Reset = 1'b1; Run = 1'b0; Step = 1'b0; Stall = 1'b0; Halt_Req = 1'b0; run2 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        zero_v = '0;
        check_outputs("reset", zero_v);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            Run = vecs[i].run; Step = vecs[i].step;
            Stall = vecs[i].stall; Halt_Req = vecs[i].hreq;
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end
        Run = 1'b0; Step = 1'b0; Stall = 1'b0; Halt_Req = 1'b0;

        // Reset between edges clears HALTED immediately.
        #2 Reset = 1'b1;
        #1;
        check("halt_reset Halted", {31'd0, Halted}, 32'd0);
        check("halt_reset InstrCount", {16'd0, InstrCount}, 32'd0);
        Reset = 1'b0;

        // Reset asynchronously mid-instruction while in stage 3.
        Run = 1'b1;
        repeat (3) tick();
        check("pre_reset Stage", {29'd0, Stage}, 32'd3);
        #3 Reset = 1'b1;
        #1;
        check("async Stage", {29'd0, Stage}, 32'd0);
        check("async Busy", {31'd0, Busy}, 32'd0);
        check("async CycleCount", {16'd0, CycleCount}, 32'd0);
        Reset = 1'b0;
        tick();
        check("restart Stage", {29'd0, Stage}, 32'd1);
        // Run falls mid-instruction: it still completes, then idles.
        Run = 1'b0;
        repeat (3) tick();
        check("no_abort Stage", {29'd0, Stage}, 32'd4);
        repeat (2) tick();
        check("no_abort end Stage", {29'd0, Stage}, 32'd0);
        check("no_abort InstrCount", {16'd0, InstrCount}, 32'd1);

        // CNT_W=4: 17 instructions; retire k happens on edge 5k+1.
        Reset = 1'b1;
        #2 Reset = 1'b0;
        run2 = 1'b1;
        repeat (81) tick();
        check("wrap16 icnt", {28'd0, icnt2}, 32'd0);
        check("wrap16 stage", {29'd0, stage2}, 32'd1);
        check("sat ccnt early", {28'd0, ccnt2}, 32'd15);
        run2 = 1'b0;
        repeat (5) tick();
        check("wrap17 icnt", {28'd0, icnt2}, 32'd1);
        check("wrap17 ccnt", {28'd0, ccnt2}, 32'd15);
        check("wrap17 stage", {29'd0, stage2}, 32'd0);
        check("wrap17 done", {31'd0, done2}, 32'd1);
        check("wrap17 busy", {31'd0, busy2}, 32'd0);
        check("wrap17 halted", {31'd0, halted2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
